// File: rtl/iob_eth_buf_responder.sv
// IOb responder terminating the Ethernet MAC data master: word-organised packet
// buffer with programmable wait states, byte strobes, error flagging and counters.
module iob_eth_buf_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                BUF_ADDR_W  = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [DATA_W/8-1:0] sel_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                err_o,
  input  logic                clear_i,
  output logic [15:0]         rd_cnt_o,
  output logic [15:0]         wr_cnt_o,
  output logic [15:0]         err_cnt_o
);

  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 2 ** BUF_ADDR_W;
  localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] END_EXT  = BASE_EXT + ((ADDR_W+1)'(1) << (BUF_ADDR_W + 2));
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic bad_q, bad_d;
  logic wr_q, wr_d;
  logic [BUF_ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0] wstrb_q, wstrb_d;
  logic [NB-1:0] sel_q, sel_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata_q;
  logic ram_re, ram_we;
  logic [BUF_ADDR_W-1:0] ram_ridx;

  logic [ADDR_W:0] addr_ext;
  logic [ADDR_W-1:0] addr_off;
  logic req_bad;
  logic [BUF_ADDR_W-1:0] req_idx;
  logic in_resp;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [15:0] cnt_next(input logic [15:0] c, input logic inc,
                                           input logic clr);
    if (clr) return 16'h0000;
    if (inc && (c != 16'hFFFF)) return c + 16'h0001;
    return c;
  endfunction

  // Request decode on the live bus; only consumed in IDLE.
  always_comb begin
    addr_ext = {1'b0, addr_i};
    addr_off = addr_i - BASE_ADDR;
    req_bad  = (addr_i[1:0] != 2'b00) || (addr_ext < BASE_EXT) || (addr_ext >= END_EXT);
    req_idx  = BUF_ADDR_W'(addr_off >> 2);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    bad_d    = bad_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    sel_d    = sel_q;
    ram_re   = 1'b0;
    ram_ridx = idx_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          bad_d   = req_bad;
          wr_d    = |wstrb_i;
          idx_d   = req_idx;
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          sel_d   = sel_i;
          cnt_d   = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            // Zero wait: the RAM read must be issued from the live address.
            state_d  = S_RESP;
            ready_d  = 1'b1;
            err_d    = req_bad;
            ram_re   = 1'b1;
            ram_ridx = req_idx;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          err_d   = bad_q;
          ram_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_resp   = (state_q == S_RESP);
    ram_we    = in_resp && wr_q && !bad_q;
    rd_cnt_d  = cnt_next(rd_cnt_q, in_resp && !bad_q && !wr_q, clear_i);
    wr_cnt_d  = cnt_next(wr_cnt_q, in_resp && !bad_q && wr_q, clear_i);
    err_cnt_d = cnt_next(err_cnt_q, in_resp && bad_q, clear_i);
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Latched request fields: always reloaded in IDLE before use, so no reset.
  always_ff @(posedge clk_i) begin
    bad_q   <= bad_d;
    wr_q    <= wr_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    sel_q   <= sel_d;
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
    if (ram_re) ram_rdata_q <= mem[ram_ridx];
  end

  assign ready_o   = ready_q;
  assign err_o     = err_q;
  assign rdata_o   = (ready_q && !err_q && !wr_q) ? (ram_rdata_q & lane_mask(sel_q)) : '0;
  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_iob_eth_buf_responder.sv
// Directed bench for iob_eth_buf_responder: one instance with one wait state,
// one with zero wait states for back-to-back and counter-saturation sequences.
module tb_iob_eth_buf_responder;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  sel;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        arst  [2];
  logic        valid [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic [3:0]  sel   [2];
  logic        clear [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic [15:0] rdc   [2];
  logic [15:0] wrc   [2];
  logic [15:0] erc   [2];

  int nvec = 0;
  int nmis = 0;
  vec_t tbl [14];

  iob_eth_buf_responder #(.ADDR_W(32), .DATA_W(32), .BUF_ADDR_W(9),
                          .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk_i(clk), .arst_i(arst[0]), .valid_i(valid[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .sel_i(sel[0]), .rdata_o(rdata[0]),
    .ready_o(ready[0]), .err_o(err[0]), .clear_i(clear[0]), .rd_cnt_o(rdc[0]),
    .wr_cnt_o(wrc[0]), .err_cnt_o(erc[0]));

  iob_eth_buf_responder #(.ADDR_W(32), .DATA_W(32), .BUF_ADDR_W(9),
                          .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i(clk), .arst_i(arst[1]), .valid_i(valid[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .sel_i(sel[1]), .rdata_o(rdata[1]),
    .ready_o(ready[1]), .err_o(err[1]), .clear_i(clear[1]), .rd_cnt_o(rdc[1]),
    .wr_cnt_o(wrc[1]), .err_cnt_o(erc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input int d, input string nm, input logic [15:0] r,
                         input logic [15:0] w, input logic [15:0] e);
    chk({nm, " rd_cnt"}, {16'h0, rdc[d]}, {16'h0, r});
    chk({nm, " wr_cnt"}, {16'h0, wrc[d]}, {16'h0, w});
    chk({nm, " err_cnt"}, {16'h0, erc[d]}, {16'h0, e});
  endtask

  // Issue one request at a negedge, wait (bounded) for ready, check the response,
  // then drop valid and step past the RESP cycle so counters have settled.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [3:0] sl,
                     input logic [31:0] exp_rd, input logic exp_e, input int exp_lat,
                     input bit do_clear, input string nm);
    int lat;
    bit quiet;
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = st;
    sel[d]   = sl;
    lat   = 0;
    quiet = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!ready[d] && (rdata[d] != 32'h0 || err[d])) quiet = 1'b0;
    end while (!ready[d] && lat < 20);
    chk({nm, " ready"}, {31'h0, ready[d]}, 32'h1);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " rdata"}, rdata[d], exp_rd);
    chk({nm, " err"}, {31'h0, err[d]}, {31'h0, exp_e});
    chk({nm, " idle outputs quiet"}, {31'h0, quiet}, 32'h1);
    if (do_clear) clear[d] = 1'b1;
    valid[d] = 1'b0;
    @(negedge clk);
    clear[d] = 1'b0;
    chk({nm, " ready single cycle"}, {31'h0, ready[d]}, 32'h0);
  endtask

  initial begin
    int k;
    tbl[0]  = '{32'h010, 32'hDEADBEEF, 4'hF, 4'h0, 32'h00000000, 1'b0};
    tbl[1]  = '{32'h010, 32'h00000000, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{32'h020, 32'h11223344, 4'hF, 4'h0, 32'h00000000, 1'b0};
    tbl[3]  = '{32'h020, 32'h000000AA, 4'h1, 4'h0, 32'h00000000, 1'b0};
    tbl[4]  = '{32'h020, 32'h00000000, 4'h0, 4'hF, 32'h112233AA, 1'b0};
    tbl[5]  = '{32'h020, 32'h00000000, 4'h0, 4'h3, 32'h000033AA, 1'b0};
    tbl[6]  = '{32'h000, 32'h01020304, 4'hF, 4'h0, 32'h00000000, 1'b0};
    tbl[7]  = '{32'h800, 32'hFFFFFFFF, 4'hF, 4'h0, 32'h00000000, 1'b1};
    tbl[8]  = '{32'h802, 32'h00000000, 4'h0, 4'hF, 32'h00000000, 1'b1};
    tbl[9]  = '{32'h000, 32'h00000000, 4'h0, 4'hF, 32'h01020304, 1'b0};
    tbl[10] = '{32'h7FC, 32'hCAFEF00D, 4'hF, 4'h0, 32'h00000000, 1'b0};
    tbl[11] = '{32'h7FC, 32'h00000000, 4'h0, 4'hC, 32'hCAFE0000, 1'b0};
    tbl[12] = '{32'h013, 32'h00000000, 4'h0, 4'hF, 32'h00000000, 1'b1};
    tbl[13] = '{32'h030, 32'h55555555, 4'hF, 4'h0, 32'h00000000, 1'b0};

    for (int d = 0; d < 2; d++) begin
      arst[d] = 1'b0; valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      wstrb[d] = '0; sel[d] = '0; clear[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset ready", {31'h0, ready[0]}, 32'h0);
    chk("reset err", {31'h0, err[0]}, 32'h0);
    chk("reset rdata", rdata[0], 32'h0);
    chk_cnt(0, "reset", 16'h0, 16'h0, 16'h0);
    arst[0] = 1'b1;
    arst[1] = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      txn(0, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].sel,
          tbl[i].exp_rdata, tbl[i].exp_err, 2, 1'b0, $sformatf("vec%0d", i));
    chk_cnt(0, "after table", 16'd5, 16'd6, 16'd3);

    // Reset while a write to 0x30 sits in WAIT: it must be abandoned.
    valid[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hAAAAAAAA; wstrb[0] = 4'hF;
    @(negedge clk);
    chk("abort in wait ready", {31'h0, ready[0]}, 32'h0);
    arst[0] = 1'b0;
    valid[0] = 1'b0;
    @(negedge clk);
    chk("abort ready", {31'h0, ready[0]}, 32'h0);
    chk_cnt(0, "abort", 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("abort still no ready", {31'h0, ready[0]}, 32'h0);
    arst[0] = 1'b1;
    @(negedge clk);
    txn(0, 32'h30, 32'h0, 4'h0, 4'hF, 32'h55555555, 1'b0, 2, 1'b0, "post-abort read");
    chk_cnt(0, "post-abort", 16'd1, 16'd0, 16'd0);

    // Clear coinciding with a read increment: clear wins.
    txn(0, 32'h34, 32'h12345678, 4'hF, 4'h0, 32'h0, 1'b0, 2, 1'b0, "pre-clear write");
    txn(0, 32'h804, 32'h0, 4'h0, 4'hF, 32'h0, 1'b1, 2, 1'b0, "pre-clear err");
    chk_cnt(0, "pre-clear", 16'd1, 16'd1, 16'd1);
    txn(0, 32'h34, 32'h0, 4'h0, 4'hF, 32'h12345678, 1'b0, 2, 1'b1, "clear read");
    chk_cnt(0, "clear", 16'd0, 16'd0, 16'd0);

    // Zero-wait instance: fill four words, then stream reads with valid held high.
    for (int i = 0; i < 4; i++)
      txn(1, 32'h40 + 4*i, 32'hA0000000 + i, 4'hF, 4'h0, 32'h0, 1'b0, 1, 1'b0,
          $sformatf("w0 fill%0d", i));
    addr[1] = 32'h40; wstrb[1] = 4'h0; sel[1] = 4'hF; valid[1] = 1'b1;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b ready cyc%0d", i), {31'h0, ready[1]}, {31'h0, 1'(i % 2)});
      if (ready[1]) begin
        chk($sformatf("b2b data%0d", k), rdata[1], 32'hA0000000 + k);
        k++;
        if (k == 4) valid[1] = 1'b0;
        else addr[1] = 32'h40 + 4*k;
      end
    end
    chk_cnt(1, "b2b", 16'd4, 16'd4, 16'd0);
    txn(1, 32'h1000, 32'h0, 4'h0, 4'hF, 32'h0, 1'b1, 1, 1'b0, "w0 range err");

    // Preload the read counter near the top instead of issuing 65534 reads.
    u_dut_w0.rd_cnt_q = 16'hFFFE;
    txn(1, 32'h40, 32'h0, 4'h0, 4'hF, 32'hA0000000, 1'b0, 1, 1'b0, "sat read1");
    chk("sat reaches top", {16'h0, rdc[1]}, 32'h0000FFFF);
    txn(1, 32'h44, 32'h0, 4'h0, 4'h1, 32'h00000001, 1'b0, 1, 1'b0, "sat read2");
    chk("sat holds top", {16'h0, rdc[1]}, 32'h0000FFFF);
    chk("sat err_cnt", {16'h0, erc[1]}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/iob_eth_buf_responder.md
Name: iob_eth_buf_responder

Overview:
- IOb-bus responder (slave) that terminates the Ethernet MAC's IOb data master (d_* bus): single-port word-organised packet/descriptor buffer answering DMA reads and writes.
- Programmable wait states, byte-strobe writes, range/alignment error reporting, and saturating transaction counters for bring-up and debug.
- Placed in the SoC between the MAC wrapper's data master and on-chip RAM. Also serves as the standalone DMA target in MAC simulation benches.

Parameters:
- ADDR_W, 32, IOb byte-address width; must equal the MAC wrapper's MEM_ADDR_W.
- DATA_W, 32, data width; only 32 is supported.
- BUF_ADDR_W, 9, log2 of the buffer depth in words (default 512 words = 2 KiB).
- BASE_ADDR, 0, byte base address of the buffer window; must be 4-byte aligned.
- WAIT_CYCLES, 1, extra response latency in cycles; legal range 0..15.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  request valid; initiator holds it until ready_o.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  write data.
- wstrb_i  in  DATA_W/8  byte write strobes; all zero means a read.
- sel_i  in  DATA_W/8  byte lane select for reads.
- rdata_o  out  DATA_W  read data; valid only while ready_o=1.
- ready_o  out  1  one-cycle response strobe.
- err_o  out  1  error flag; valid only while ready_o=1.
- clear_i  in  1  synchronous clear of the counters.
- rd_cnt_o  out  16  number of completed good reads.
- wr_cnt_o  out  16  number of completed good writes.
- err_cnt_o  out  16  number of errored transactions.

Behaviour:
- Reset (arst_i=0): FSM goes to IDLE. ready_o=0, err_o=0, rdata_o=0, all counters=0. Buffer contents are not reset.
- Reset mid-transaction aborts the transaction: no write, no response. Initiator must reissue after reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - On valid_i=1, latch addr, wdata, wstrb and sel.
  - Compute bad = addr[1:0]!=0 OR addr<BASE_ADDR OR addr>=BASE_ADDR+4*2^BUF_ADDR_W.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 1. Changes on request inputs during WAIT are ignored.
- Word index = (addr-BASE_ADDR)[BUF_ADDR_W+1:2]. The RAM read is issued on entry so read data is registered in time for RESP.
- RESP: ready_o=1 for exactly one cycle, then return to IDLE.
  - Good write: each byte lane with wstrb bit set is written in this cycle. rdata_o=0, err_o=0.
  - Good read: rdata_o = RAM word with lanes whose sel bit is 0 forced to 0. err_o=0.
  - Bad access (read or write): err_o=1, rdata_o=0, no RAM write.
- Latency: ready_o asserts WAIT_CYCLES+1 cycles after the cycle in which IDLE samples valid_i=1.
- Back-to-back: valid_i still high in the cycle after ready_o is treated as a new request (sampled in IDLE). Peak throughput is 1 transaction per WAIT_CYCLES+2 cycles.
- Outside RESP: ready_o=0, err_o=0, rdata_o=0.
- Read after write to the same word returns the newly written data. There is no hazard because transactions are serialised.
- Counters:
  - Each increments in the RESP cycle of its transaction class.
  - Each saturates at 0xFFFF.
  - clear_i=1 zeroes all three; if clear and increment coincide, clear wins.

Test Plan:
- Reset, WAIT_CYCLES=1: write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 with sel=0xF -> each ready_o asserts 2 cycles after valid; read returns 0xDEADBEEF, err_o=0; wr_cnt_o=1, rd_cnt_o=1.
- Partial strobe: 0x11223344 at 0x20, then write 0x000000AA with wstrb=0x1, then read with sel=0xF -> 0x112233AA. Read with sel=0x3 -> 0x000033AA.
- Errors (BASE_ADDR=0, BUF_ADDR_W=9): write to 0x800 -> err_o=1, no RAM change, err_cnt_o=1. Read of 0x802 -> err_o=1, rdata_o=0, err_cnt_o=2.
- WAIT_CYCLES=0 with valid_i held high over 4 reads -> ready_o pulses every 2nd cycle, each with correct data; rd_cnt_o=4.
- Assert arst_i=0 during WAIT of a write to 0x30 (prior content 0x55555555) -> no ready_o; read after release returns 0x55555555; counters=0.
- Preload rd_cnt_o=0xFFFF with 65535 reads -> one more read keeps 0xFFFF. clear_i in the same cycle as an increment -> all counters read 0.
